mux_4to1: RTL and testbench
===========================

// Module: mux_4to1
// PURPOSE
//   Parameterised 4:1 data selector used as a generic steering primitive in datapaths.
//   Provides a combinational output y that follows inputs and selects with zero latency.
//   Also provides a registered copy y_q, with a load enable, for timing-closed consumers.
//   One clock domain; synchronous active-low reset affects only the registered outputs.
// PARAMETERS
//   WIDTH     1   bit width of each data input and of y / y_q
//   RST_VAL   0   value loaded into y_q on reset (WIDTH bits, zero-extended)
// PORTS
//   clk       in   1      rising-edge clock for the registered path
//   rst_n     in   1      synchronous active-low reset, sampled on posedge clk
//   i0        in   WIDTH  data input, selected when {sel1,sel2}=2'b00
//   i1        in   WIDTH  data input, selected when {sel1,sel2}=2'b01
//   i2        in   WIDTH  data input, selected when {sel1,sel2}=2'b10
//   i3        in   WIDTH  data input, selected when {sel1,sel2}=2'b11
//   sel1      in   1      select MSB
//   sel2      in   1      select LSB
//   load      in   1      when 1, y_q captures y at the next posedge clk
//   y         out  WIDTH  combinational mux output
//   y_q       out  WIDTH  registered mux output
//   sel_q     out  2      registered {sel1,sel2} captured alongside y_q
// BEHAVIOUR
//   - Select index is {sel1,sel2}; sel1 is the MSB. Mapping: 00->i0, 01->i1, 10->i2, 11->i3.
//   - y is purely combinational from i0..i3, sel1 and sel2.
//     * No clock dependency; rst_n has no effect on y.
//     * y settles within one delta of an input change.
//   - If sel1 or sel2 is X/Z in simulation, y = all-X. Synthesis may treat X as don't-care.
//   - Registered path:
//     * At posedge clk with rst_n=0: y_q <= RST_VAL and sel_q <= 2'b00, regardless of load.
//     * At posedge clk with rst_n=1 and load=1: y_q <= y and sel_q <= {sel1,sel2}.
//     * At posedge clk with rst_n=1 and load=0: y_q and sel_q hold their values.
//   - Latency: y is 0 cycles; y_q / sel_q are 1 cycle after the load edge.
//   - Reset asserted mid-operation clears y_q / sel_q at the next edge; y is unaffected throughout.
//   - Before the first clock edge, y_q / sel_q are undefined. No asynchronous path exists.
//   - Width rule: all data ports are exactly WIDTH bits; no truncation or extension occurs.
// TESTING
//   1) i0=1,i1=0,i2=0,i3=0, sel1=0,sel2=0 -> y=1 within 10 ns, no clock needed.
//   2) i1=1, others 0, sel1=0,sel2=1 -> y=1; then flip i1 to 0 -> y=0.
//   3) i2=1, others 0, sel1=1,sel2=0 -> y=1; then set sel2=1 with i3=0 -> y=0.
//   4) i3=1, others 0, sel1=1,sel2=1 -> y=1; exhaustive sweep of all 64 input combos (WIDTH=1) matches the mapping.
//   5) rst_n=0 for 1 edge -> y_q=0, sel_q=00. Then rst_n=1, load=1, sel=10, i2=1 -> after 1 edge y_q=1, sel_q=10.
//      Then load=0 with changing inputs -> y_q holds 1.
//   6) With load=1, assert rst_n=0 for one edge -> y_q=RST_VAL at that edge while y keeps tracking inputs.

Source files
------------

// File: rtl/mux_4to1_if.sv
// Bundles the four data inputs, the select bits, the load strobe and the three
// mux outputs for mux_4to1. The master drives the data and selects; the slave is the mux.
interface mux_4to1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic             sel1;
  logic             sel2;
  logic             load;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_q;

  modport master (
    output i0, i1, i2, i3, sel1, sel2, load,
    input  y, y_q, sel_q
  );

  modport slave (
    input  i0, i1, i2, i3, sel1, sel2, load,
    output y, y_q, sel_q
  );
endinterface

// File: rtl/mux_4to1.sv
// Parameterised 4:1 selector with a zero-latency combinational output and a
// load-enabled registered copy (plus the select that produced it).
module mux_4to1 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_4to1_if.slave   bus
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_yQ;
  logic [1:0]       r_selQ;

  assign w_sel = {bus.sel1, bus.sel2};

  // An unknown select yields all-X in simulation; synthesis treats it as don't-care.
  always_comb begin
    w_y = 'x;
    case (w_sel)
      2'b00:   w_y = bus.i0;
      2'b01:   w_y = bus.i1;
      2'b10:   w_y = bus.i2;
      2'b11:   w_y = bus.i3;
      default: w_y = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_yQ   <= RST_VAL;
      r_selQ <= 2'b00;
    end else if (bus.load) begin
      r_yQ   <= w_y;
      r_selQ <= w_sel;
    end
  end

  assign bus.y     = w_y;
  assign bus.y_q   = r_yQ;
  assign bus.sel_q = r_selQ;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed cases on a 1-bit instance, then
// randomized traffic on an 8-bit instance with a non-zero reset value.
module tb_mux_4to1;

  localparam int              WB    = 8;
  localparam logic [WB-1:0]   RSTVB = 8'hA5;

  logic clk;
  logic rstNA;
  logic rstNB;
  int   totalChecks;
  int   badChecks;

  mux_4to1_if #(.WIDTH(1))  busA ();
  mux_4to1_if #(.WIDTH(WB)) busB ();

  mux_4to1 #(.WIDTH(1), .RST_VAL(1'b0)) dutA (
    .clk   (clk),
    .rst_n (rstNA),
    .bus   (busA.slave)
  );

  mux_4to1 #(.WIDTH(WB), .RST_VAL(RSTVB)) dutB (
    .clk   (clk),
    .rst_n (rstNB),
    .bus   (busB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setA(input logic a0, input logic a1, input logic a2, input logic a3,
                      input logic s1, input logic s2);
    busA.i0   = a0;
    busA.i1   = a1;
    busA.i2   = a2;
    busA.i3   = a3;
    busA.sel1 = s1;
    busA.sel2 = s2;
  endtask

  // Reference model for the wide instance: pick by index, and track the registered copy.
  logic [WB-1:0] expYq;
  logic [1:0]    expSelQ;

  task automatic applyStimulus(input logic [WB-1:0] d0, input logic [WB-1:0] d1,
                               input logic [WB-1:0] d2, input logic [WB-1:0] d3,
                               input logic s1, input logic s2, input logic ld,
                               input logic rn);
    logic [WB-1:0] data [4];
    int            idx;
    logic [WB-1:0] expY;
    @(negedge clk);
    busB.i0 = d0; busB.i1 = d1; busB.i2 = d2; busB.i3 = d3;
    busB.sel1 = s1; busB.sel2 = s2; busB.load = ld; rstNB = rn;
    data[0] = d0; data[1] = d1; data[2] = d2; data[3] = d3;
    idx  = 2 * int'(s1) + int'(s2);
    expY = data[idx];
    #1;
    checkOutput("rnd_y", 32'(busB.y), 32'(expY));
    if (!rn) begin
      expYq   = RSTVB;
      expSelQ = 2'b00;
    end else if (ld) begin
      expYq   = expY;
      expSelQ = 2'(idx);
    end
    @(posedge clk);
    #1;
    checkOutput("rnd_yq", 32'(busB.y_q), 32'(expYq));
    checkOutput("rnd_selq", 32'(busB.sel_q), 32'(expSelQ));
  endtask

  initial begin
    logic [5:0] bits;
    logic       vals [4];
    totalChecks = 0;
    badChecks   = 0;
    rstNA = 1'b1;
    rstNB = 1'b1;
    busA.load = 1'b0;
    busB.load = 1'b0;
    busB.i0 = '0; busB.i1 = '0; busB.i2 = '0; busB.i3 = '0;
    busB.sel1 = 1'b0; busB.sel2 = 1'b0;

    // Combinational path, no clock edge involved yet.
    setA(1, 0, 0, 0, 0, 0); #1;
    checkOutput("t1_y", 32'(busA.y), 32'd1);
    setA(0, 1, 0, 0, 0, 1); #1;
    checkOutput("t2_y_hi", 32'(busA.y), 32'd1);
    busA.i1 = 1'b0; #1;
    checkOutput("t2_y_lo", 32'(busA.y), 32'd0);
    setA(0, 0, 1, 0, 1, 0); #1;
    checkOutput("t3_y_hi", 32'(busA.y), 32'd1);
    busA.sel2 = 1'b1; #1;
    checkOutput("t3_y_sel", 32'(busA.y), 32'd0);
    setA(0, 0, 0, 1, 1, 1); #1;
    checkOutput("t4_y", 32'(busA.y), 32'd1);

    for (int v = 0; v < 64; v++) begin
      bits = 6'(v);
      vals[0] = bits[5]; vals[1] = bits[4]; vals[2] = bits[3]; vals[3] = bits[2];
      setA(bits[5], bits[4], bits[3], bits[2], bits[1], bits[0]); #1;
      checkOutput("sweep_y", 32'(busA.y), 32'(vals[2 * int'(bits[1]) + int'(bits[0])]));
    end

    // Registered path: reset, load, hold.
    @(negedge clk);
    rstNA = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_rst_yq", 32'(busA.y_q), 32'd0);
    checkOutput("t5_rst_selq", 32'(busA.sel_q), 32'd0);
    rstNA = 1'b1;
    busA.load = 1'b1;
    setA(0, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    checkOutput("t5_load_yq", 32'(busA.y_q), 32'd1);
    checkOutput("t5_load_selq", 32'(busA.sel_q), 32'd2);
    busA.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bits = 6'($urandom);
      setA(bits[5], bits[4], bits[3], bits[2], bits[1], bits[0]);
      @(posedge clk); #1;
      checkOutput("t5_hold_yq", 32'(busA.y_q), 32'd1);
      checkOutput("t5_hold_selq", 32'(busA.sel_q), 32'd2);
    end

    // Reset wins over load, and y keeps tracking while reset is low.
    busA.load = 1'b1;
    setA(1, 0, 0, 0, 0, 0);
    rstNA = 1'b0; #1;
    checkOutput("t6_y_pre", 32'(busA.y), 32'd1);
    @(posedge clk); #1;
    checkOutput("t6_rst_yq", 32'(busA.y_q), 32'd0);
    checkOutput("t6_rst_selq", 32'(busA.sel_q), 32'd0);
    checkOutput("t6_y_rst", 32'(busA.y), 32'd1);
    setA(0, 0, 0, 1, 1, 1); #1;
    checkOutput("t6_y_track", 32'(busA.y), 32'd1);
    rstNA = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_reload_yq", 32'(busA.y_q), 32'd1);
    checkOutput("t6_reload_selq", 32'(busA.sel_q), 32'd3);

    // Randomized traffic on the wide instance; first cycle forces a reset.
    expYq   = '0;
    expSelQ = '0;
    for (int n = 0; n < 300; n++) begin
      applyStimulus(WB'($urandom), WB'($urandom), WB'($urandom), WB'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    (n == 0) ? 1'b0 : ($urandom_range(0, 9) != 0));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
